uart_pixel_loader: RTL and testbench
====================================

# uart_pixel_loader

Frame parser between `uart_rx` and the Sobel pixel pipeline. It consumes the received byte stream (`rx_data`/`rx_valid`) and decodes a framed image packet: a sync byte, then width and height, then raw 8-bit grayscale pixels. Pixels go out on a valid/ready stream with start-of-frame, end-of-line and end-of-frame flags. A small FIFO absorbs downstream stalls, because the UART source cannot be backpressured.

## Interface
- `FIFO_DEPTH`, 16: pixel FIFO entries; power of two, ≥4.
- `MAX_DIM`, 640: largest accepted width or height.
- `TIMEOUT_CLKS`, 270000: idle clocks between bytes, mid-packet, before the packet is aborted (10 ms at 27 MHz).
- `SYNC_BYTE`, 8'hA5: packet start marker.
- `clk` input 1: single clock for all logic.
- `rst` input 1: reset; synchronous and active-high.
- `rx_data` input 8: byte from the UART receiver.
- `rx_valid` input 1: one-cycle strobe; `rx_data` is valid while it is high.
- `pix_data` output 8: pixel value.
- `pix_valid` output 1: FIFO head is valid.
- `pix_ready` input 1: downstream accepts the head.
- `pix_sof` output 1: head is the first pixel of the frame.
- `pix_eol` output 1: head is the last pixel of a line.
- `pix_eof` output 1: head is the last pixel of the frame.
- `frame_done` output 1: one-cycle pulse when a packet completes.
- `hdr_err` output 1: one-cycle pulse when a header is rejected.
- `chk_err` output 1: one-cycle pulse on checksum mismatch.
- `timeout` output 1: one-cycle pulse when a packet is aborted on timeout.
- `overflow` output 1: sticky; set when a pixel is dropped; cleared only by `rst`.

## Operation
Packet format: `SYNC_BYTE`, W_lo, W_hi, H_lo, H_hi, then W×H pixels in row-major order, then a checksum byte (XOR of all pixel bytes) when enabled.

State machine. Each state advances only on cycles where `rx_valid` is high.
- IDLE: a byte equal to `SYNC_BYTE` moves to HDR. Any other byte is ignored.
- HDR: captures 4 bytes into 16-bit W and H.
  - On the 4th byte, if W=0, H=0, W>`MAX_DIM` or H>`MAX_DIM`: pulse `hdr_err`, go to IDLE.
  - Otherwise go to PIX, with column and row counters and the XOR accumulator cleared.
- PIX: each byte is pushed into the FIFO with its flags.
  - `sof` is set when col=0 and row=0.
  - `eol` is set when col=W-1.
  - `eof` is set when col=W-1 and row=H-1.
  - The column counter wraps to 0 at W-1 and the row counter then increments.
  - After the eof pixel, go to CHK (macro defined) or DONE (macro undefined).
- CHK: compares the received byte with the accumulator. Pulse `frame_done`; pulse `chk_err` in the same cycle if they differ. Go to IDLE.
- DONE: is not a separate state when the checksum is compiled out. `frame_done` pulses on the eof-byte cycle and the machine goes to IDLE.

Boundary rules:
- **FIFO full when a pixel arrives, no pop that cycle:** the byte is dropped and `overflow` is set. The counters and accumulator still advance, so framing stays aligned. The accumulator includes dropped bytes.
- **FIFO full with a pop in the same cycle:** the push is accepted and the count is unchanged.
- **FIFO output:** show-ahead. `pix_valid` = not empty. A pop happens when `pix_valid` and `pix_ready` are both high.
- **Timeout:** in HDR, PIX or CHK the gap counter resets on every `rx_valid`. When it reaches `TIMEOUT_CLKS`-1, pulse `timeout` and go to IDLE. FIFO contents already queued still drain, so downstream sees a frame with no eof.
- **`SYNC_BYTE` outside IDLE:** treated as data. There is no resync mid-packet.
- **Reset:** takes effect mid-packet at the next edge. The FIFO is emptied and the state returns to IDLE.

## Timing
- **Reset values:** `pix_valid`, `pix_sof`, `pix_eol`, `pix_eof`, `frame_done`, `hdr_err`, `chk_err`, `timeout` and `overflow` are 0. `pix_data` is 0. State is IDLE, FIFO count is 0, all counters are 0.
- **Pixel latency:** with `rx_valid` high in cycle N and the FIFO empty, `pix_valid`, `pix_data` and the flags are valid in cycle N+1.
- **Status pulses:** `frame_done`, `hdr_err`, `chk_err` and `timeout` are registered. They are high for exactly cycle N+1, where N is the triggering `rx_valid` cycle (for `timeout`, the cycle the count is reached).
- **`overflow`:** rises in cycle N+1 after the dropped byte.
- **Pop timing:** after a pop in cycle M, the next head (if any) is presented in cycle M+1.
- **Throughput:** one pixel per clock on output. The input rate is bounded by the UART rate.

## Configuration
- **`LOADER_CHECKSUM_EN` defined:** the CHK state and XOR accumulator are built. The packet carries a trailing checksum byte and `chk_err` is functional.
- **`LOADER_CHECKSUM_EN` undefined:** there is no CHK state and no accumulator. The packet ends at the eof pixel and `chk_err` is tied to 0.

## Test plan
- **Nominal 4×2 frame:** send A5 04 00 02 00, pixels 10..17, checksum 0x00 (macro on), `pix_ready`=1.
  - Expect 8 pixels 0x10–0x17.
  - `sof` on 0x10; `eol` on 0x13 and 0x17; `eof` on 0x17.
  - `frame_done` pulses once and `chk_err` stays 0.
- **Bad checksum:** same frame with checksum 0xFF. Expect identical pixel output, and `frame_done` and `chk_err` high together for one cycle.
- **Header rejects:**
  - A5 00 00 05 00 → `hdr_err` pulse, no pixels.
  - A5 81 02 01 00 (W=641) → `hdr_err` pulse.
  - In both cases a following valid packet is then decoded correctly.
- **Overflow:** `pix_ready`=0, FIFO_DEPTH=16, 5×4 frame.
  - The first 16 pixels are queued and `overflow` rises on the 17th.
  - After `pix_ready`=1, exactly 16 pixels drain.
  - `frame_done` still pulses after the checksum byte.
- **Timeout and reset:**
  - Stop after the 3rd pixel of a 4×4 frame for `TIMEOUT_CLKS` cycles → `timeout` pulse, state IDLE, 3 pixels delivered with no `eof`.
  - Separately, assert `rst` mid-PIX → next cycle all outputs are 0 and the FIFO is empty.

Source files
------------

// File: rtl/uart_pixel_loader.sv
// uart_pixel_loader: decodes SYNC/W/H/pixel packets from a UART byte stream into a flagged pixel stream.
// Define LOADER_CHECKSUM_EN to expect and verify a trailing XOR checksum byte.
module uart_pixel_loader #(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_DIM = 640,
  parameter int TIMEOUT_CLKS = 270000,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] pix_data,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       pix_sof,
  output logic       pix_eol,
  output logic       pix_eof,
  output logic       frame_done,
  output logic       hdr_err,
  output logic       chk_err,
  output logic       timeout,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(TIMEOUT_CLKS);
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, HDR, PIX, CHK} state_t;
  logic [7:0] acc;
`else
  typedef enum logic [1:0] {IDLE, HDR, PIX} state_t;
  assign chk_err = 1'b0;
`endif
  state_t state;
  logic [1:0] hcnt;
  logic [7:0] h_lo;
  logic [15:0] w, h, col, row, h_new;
  logic [GW-1:0] gap;
  logic [10:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic push, pop, full, wr, sof, eol, eof;
  assign pix_valid = cnt != '0;
  assign {pix_sof, pix_eol, pix_eof, pix_data} = pix_valid ? mem[rp] : '0;
  always_comb begin
    h_new = {rx_data, h_lo};
    sof = col == '0 && row == '0;
    eol = col == w - 16'd1;
    eof = eol && row == h - 16'd1;
    push = state == PIX && rx_valid;
    full = cnt == (AW+1)'(FIFO_DEPTH);
    pop = pix_valid && pix_ready;
    wr = push && (!full || pop);
  end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= {sof, eol, eof, rx_data};
  // Pixels that find the FIFO full are dropped; framing counters still advance below.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
      if (push && !wr) overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hcnt <= '0;
      h_lo <= '0;
      w <= '0;
      h <= '0;
      col <= '0;
      row <= '0;
      gap <= '0;
      frame_done <= 1'b0;
      hdr_err <= 1'b0;
      timeout <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      acc <= '0;
      chk_err <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      hdr_err <= 1'b0;
      timeout <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_err <= 1'b0;
`endif
      if (rx_valid) begin
        gap <= '0;
        case (state)
          IDLE: if (rx_data == SYNC_BYTE) begin
            state <= HDR;
            hcnt <= '0;
          end
          HDR: begin
            hcnt <= hcnt + 2'd1;
            if (hcnt == 2'd0) w[7:0] <= rx_data;
            else if (hcnt == 2'd1) w[15:8] <= rx_data;
            else if (hcnt == 2'd2) h_lo <= rx_data;
            else begin
              h <= h_new;
              col <= '0;
              row <= '0;
`ifdef LOADER_CHECKSUM_EN
              acc <= '0;
`endif
              if (w == '0 || h_new == '0 || w > 16'(MAX_DIM) || h_new > 16'(MAX_DIM)) begin
                hdr_err <= 1'b1;
                state <= IDLE;
              end else state <= PIX;
            end
          end
          PIX: begin
            col <= eol ? '0 : col + 16'd1;
            if (eol) row <= row + 16'd1;
`ifdef LOADER_CHECKSUM_EN
            acc <= acc ^ rx_data;
            if (eof) state <= CHK;
`else
            if (eof) begin
              frame_done <= 1'b1;
              state <= IDLE;
            end
`endif
          end
`ifdef LOADER_CHECKSUM_EN
          CHK: begin
            frame_done <= 1'b1;
            chk_err <= rx_data != acc;
            state <= IDLE;
          end
`endif
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (gap == GW'(TIMEOUT_CLKS - 1)) begin
          timeout <= 1'b1;
          state <= IDLE;
          gap <= '0;
        end else gap <= gap + GW'(1);
      end
    end
  end
endmodule

// File: tb/tb_uart_pixel_loader.sv
// tb_uart_pixel_loader: randomized packet stimulus checked against a queue-based frame model.
module tb_uart_pixel_loader;
  localparam int T = 300;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic pix_ready = 1'b0;
  logic [7:0] pix_data;
  logic pix_valid, pix_sof, pix_eol, pix_eof, frame_done, hdr_err, chk_err, timeout, overflow;
  int checks = 0;
  int errors = 0;
  int fd_n, he_n, ce_n, to_n, fdce_n, to_cyc;
  int cyc = 0;
  bit rand_rdy = 0;
  logic [10:0] got[$];
  logic [7:0] pix[$];

  always #5 clk = ~clk;

  uart_pixel_loader #(.FIFO_DEPTH(16), .MAX_DIM(640), .TIMEOUT_CLKS(T), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .frame_done(frame_done), .hdr_err(hdr_err), .chk_err(chk_err),
    .timeout(timeout), .overflow(overflow)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rand_rdy) begin #1 pix_ready = ($urandom_range(0, 3) != 0); end
  always @(negedge clk) begin
    if (pix_valid && pix_ready) got.push_back({pix_sof, pix_eol, pix_eof, pix_data});
    fd_n += int'(frame_done);
    he_n += int'(hdr_err);
    ce_n += int'(chk_err);
    fdce_n += int'(frame_done && chk_err);
    if (timeout) begin
      to_n++;
      to_cyc = cyc;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    got.delete();
    fd_n = 0; he_n = 0; ce_n = 0; to_n = 0; fdce_n = 0; to_cyc = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
    tick(2);
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic send_byte(input logic [7:0] b, input int g);
    rx_data = b; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(g);
  endtask

  task automatic send_hdr(input int w, input int h);
    logic [15:0] wv, hv;
    wv = 16'(w); hv = 16'(h);
    send_byte(8'hA5, $urandom_range(0, 2));
    send_byte(wv[7:0], $urandom_range(0, 2));
    send_byte(wv[15:8], $urandom_range(0, 2));
    send_byte(hv[7:0], $urandom_range(0, 2));
    send_byte(hv[15:8], $urandom_range(0, 2));
  endtask

  task automatic make_pix(input int n);
    pix.delete();
    for (int i = 0; i < n; i++) pix.push_back(8'($urandom));
  endtask

  function automatic logic [7:0] xsum();
    logic [7:0] x = '0;
    foreach (pix[i]) x ^= pix[i];
    return x;
  endfunction

  task automatic send_tail(input logic [7:0] ck);
`ifdef LOADER_CHECKSUM_EN
    send_byte(ck, $urandom_range(0, 2));
`else
    if (ck == 8'h00) tick(0);
`endif
  endtask

  task automatic send_frame(input int w, input int h, input logic [7:0] ck);
    send_hdr(w, h);
    for (int i = 0; i < w * h; i++) send_byte(pix[i], $urandom_range(0, 2));
    send_tail(ck);
  endtask

  // Expected stream: the first n pixels of a row-major w x h frame, flags from position alone.
  task automatic expect_stream(input int w, input int h, input int n, input string nm);
    logic [10:0] e;
    int k = 0;
    while (got.size() < n && k < 1000) begin tick(1); k++; end
    tick(4);
    checks++;
    if (got.size() != n) begin
      errors++;
      $display("FAIL %s pixel_count got=%0d exp=%0d", nm, got.size(), n);
    end
    for (int i = 0; i < n && i < got.size(); i++) begin
      e = {1'(i == 0), 1'(i % w == w - 1), 1'(i == w * h - 1), pix[i]};
      checks++;
      if (got[i] !== e) begin
        errors++;
        $display("FAIL %s pixel[%0d] got=%h exp=%h", nm, i, got[i], e);
      end
    end
  endtask

  task automatic check_int(input int act, input int exp, input string nm);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    logic [16:0] v;
    v = {pix_valid, pix_sof, pix_eol, pix_eof, pix_data, frame_done, hdr_err, chk_err, timeout, overflow};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s outputs got=%h exp=0", nm, v);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_idle_outputs("reset");
  endtask

  task automatic test_nominal();
    apply_reset();
    pix_ready = 1'b1;
    pix.delete();
    for (int i = 0; i < 8; i++) pix.push_back(8'(8'h10 + i));
    send_frame(4, 2, 8'h00);
    expect_stream(4, 2, 8, "nominal");
    check_int(fd_n, 1, "nominal frame_done");
    check_int(ce_n, 0, "nominal chk_err");
  endtask

  task automatic test_bad_chk();
`ifdef LOADER_CHECKSUM_EN
    apply_reset();
    pix_ready = 1'b1;
    send_frame(4, 2, 8'hFF);
    expect_stream(4, 2, 8, "badchk");
    check_int(fd_n, 1, "badchk frame_done");
    check_int(fdce_n, 1, "badchk frame_done_with_chk_err");
    check_int(ce_n, 1, "badchk chk_err");
`endif
  endtask

  task automatic test_hdr_reject();
    apply_reset();
    pix_ready = 1'b1;
    send_hdr(0, 5);
    tick(3);
    check_int(he_n, 1, "hdr w0 hdr_err");
    check_int(got.size(), 0, "hdr w0 pixels");
    make_pix(6);
    send_frame(3, 2, xsum());
    expect_stream(3, 2, 6, "after w0");
    check_int(he_n, 1, "after w0 hdr_err");
    clear_mon();
    send_hdr(641, 1);
    tick(3);
    check_int(he_n, 1, "hdr w641 hdr_err");
    make_pix(8);
    send_frame(2, 4, xsum());
    expect_stream(2, 4, 8, "after w641");
    check_int(fd_n, 1, "after w641 frame_done");
    clear_mon();
    make_pix(640);
    send_frame(640, 1, xsum());
    expect_stream(640, 1, 640, "w640");
    check_int(he_n, 0, "w640 hdr_err");
    check_int(fd_n, 1, "w640 frame_done");
  endtask

  task automatic test_overflow();
    apply_reset();
    pix_ready = 1'b0;
    make_pix(20);
    send_hdr(5, 4);
    for (int i = 0; i < 20; i++) begin
      send_byte(pix[i], $urandom_range(0, 2));
      if (i == 15) check_int(int'(overflow), 0, "overflow after 16th");
      if (i == 16) check_int(int'(overflow), 1, "overflow after 17th");
    end
    send_tail(xsum());
    tick(2);
    check_int(fd_n, 1, "overflow frame_done");
    check_int(ce_n, 0, "overflow chk_err");
    check_int(got.size(), 0, "overflow held");
    pix_ready = 1'b1;
    expect_stream(5, 4, 16, "overflow drain");
    check_int(int'(overflow), 1, "overflow sticky");
  endtask

  task automatic test_timeout();
    int start, k;
    apply_reset();
    pix_ready = 1'b1;
    make_pix(16);
    send_hdr(4, 4);
    send_byte(pix[0], 1);
    send_byte(pix[1], 2);
    send_byte(pix[2], 0);
    start = cyc;
    k = 0;
    while (to_n == 0 && k < T + 20) begin tick(1); k++; end
    tick(2);
    check_int(to_n, 1, "timeout pulses");
    checks++;
    if (to_cyc - start < T - 1 || to_cyc - start > T + 1) begin
      errors++;
      $display("FAIL timeout latency got=%0d exp=%0d", to_cyc - start, T);
    end
    expect_stream(4, 4, 3, "timeout partial");
    clear_mon();
    make_pix(4);
    send_frame(2, 2, xsum());
    expect_stream(2, 2, 4, "after timeout");
    check_int(fd_n, 1, "after timeout frame_done");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    pix_ready = 1'b0;
    make_pix(16);
    send_hdr(4, 4);
    for (int i = 0; i < 5; i++) send_byte(pix[i], $urandom_range(0, 2));
    check_int(int'(pix_valid), 1, "midrst queued");
    rst = 1'b1;
    tick(1);
    check_idle_outputs("midrst");
    rst = 1'b0;
    clear_mon();
    pix_ready = 1'b1;
    make_pix(6);
    send_frame(2, 3, xsum());
    expect_stream(2, 3, 6, "after midrst");
  endtask

  task automatic test_back_to_back();
    int w, h;
    apply_reset();
    rand_rdy = 1;
    for (int it = 0; it < 8; it++) begin
      w = it == 0 ? 1 : it == 1 ? 3 : $urandom_range(1, 4);
      h = it == 0 ? 3 : it == 1 ? 1 : $urandom_range(1, 4);
      clear_mon();
      make_pix(w * h);
      if ($urandom_range(0, 1) == 1) send_byte(8'h3C, 1);
      send_frame(w, h, xsum());
      expect_stream(w, h, w * h, "random");
      check_int(fd_n, 1, "random frame_done");
      check_int(ce_n, 0, "random chk_err");
    end
    rand_rdy = 0;
    tick(2);
    check_int(int'(overflow), 0, "random no overflow");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_chk();
    test_hdr_reject();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
